// File: rtl/pll_lock_reset_seq.sv
// PLL lock supervisor and fabric reset sequencer with bounded PLL power-cycle retries.
// Optional: define PLL_LOCK_LOSS_CNT_EN to add the saturating loss_cnt output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | external reset asserted, retries cleared, waiting for ext_s
// WAIT_LOCK | waiting for synchronized lock, timeout running
// STABLE    | lock seen, counting consecutive lock cycles
// HOLD      | lock accepted, fabric still held in reset
// RUN       | fabric released, watching for lock loss
// PD        | PLL powered down for one retry attempt
// FAULT     | retries exhausted, stuck until ext_s=0 or resetn
module pll_lock_reset_seq #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int PD_CYCLES           = 256,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       ext_rst_n,
  output logic       pll_powerdown_n,
  output logic       fabric_reset_n,
  output logic       lock_lost,
  output logic       fault,
  output logic [2:0] state
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int MAX_AB  = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_CD  = (LOCK_TIMEOUT_CYCLES > PD_CYCLES) ? LOCK_TIMEOUT_CYCLES : PD_CYCLES;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PD_TC      = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4,
    S_PD        = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t           st;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       retry_cnt;
  logic             lock_meta;
  logic             lock_s;
  logic             ext_meta;
  logic             ext_s;

  assign state = st;

  // ext_s starts at 0 after resetn, so the FSM cannot leave IDLE until
  // reset release has passed through the synchronizer.
  always_comb begin
    nxt = st;
    if (!ext_s) begin
      nxt = S_IDLE;
    end else begin
      case (st)
        S_IDLE:      nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s)                 nxt = S_STABLE;
          else if (cnt == TIMEOUT_TC) nxt = (retry_cnt < RETRY_MAX) ? S_PD : S_FAULT;
        end
        S_STABLE: begin
          if (!lock_s)               nxt = S_WAIT_LOCK;
          else if (cnt == STABLE_TC) nxt = S_HOLD;
        end
        S_HOLD: begin
          if (!lock_s)             nxt = S_WAIT_LOCK;
          else if (cnt == HOLD_TC) nxt = S_RUN;
        end
        S_RUN:   if (!lock_s) nxt = S_WAIT_LOCK;
        S_PD:    if (cnt == PD_TC) nxt = S_WAIT_LOCK;
        S_FAULT: nxt = S_FAULT;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta       <= 1'b0;
      lock_s          <= 1'b0;
      ext_meta        <= 1'b0;
      ext_s           <= 1'b0;
      st              <= S_IDLE;
      cnt             <= '0;
      retry_cnt       <= 4'd0;
      fabric_reset_n  <= 1'b0;
      pll_powerdown_n <= 1'b1;
      lock_lost       <= 1'b0;
      fault           <= 1'b0;
`ifdef PLL_LOCK_LOSS_CNT_EN
      loss_cnt        <= 8'd0;
`endif
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      ext_meta  <= ext_rst_n;
      ext_s     <= ext_meta;
      st        <= nxt;

      if (nxt != st || st == S_IDLE || st == S_RUN || st == S_FAULT) cnt <= '0;
      else                                                           cnt <= cnt + CNT_ONE;

      if (st == S_IDLE || st == S_RUN)
        retry_cnt <= 4'd0;
      else if (st == S_WAIT_LOCK && nxt == S_PD && retry_cnt != 4'hF)
        retry_cnt <= retry_cnt + 4'd1;

      // Outputs follow the next state so they change on the same edge as STATE.
      fabric_reset_n  <= (nxt == S_RUN);
      pll_powerdown_n <= (nxt != S_PD);
      fault           <= (nxt == S_FAULT);

      if (!ext_s)                                lock_lost <= 1'b0;
      else if (st == S_RUN && nxt == S_WAIT_LOCK) lock_lost <= 1'b1;

`ifdef PLL_LOCK_LOSS_CNT_EN
      if (st == S_RUN && nxt == S_WAIT_LOCK && loss_cnt != 8'hFF)
        loss_cnt <= loss_cnt + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench for pll_lock_reset_seq: expectations are queued with the edge
// number at which they must hold and compared on the following falling edge.
module tb_pll_lock_reset_seq;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       ext_rst_n;
  logic       pll_powerdown_n;
  logic       fabric_reset_n;
  logic       lock_lost;
  logic       fault;
  logic [2:0] state;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  pll_lock_reset_seq #(
    .LOCK_STABLE_CYCLES (16),
    .RESET_HOLD_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES(100),
    .PD_CYCLES          (10),
    .MAX_RETRIES        (2)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .pll_lock       (pll_lock),
    .ext_rst_n      (ext_rst_n),
    .pll_powerdown_n(pll_powerdown_n),
    .fabric_reset_n (fabric_reset_n),
    .lock_lost      (lock_lost),
    .fault          (fault),
    .state          (state)
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    .loss_cnt       (loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {SIG_FAB, SIG_PDN, SIG_LL, SIG_FLT, SIG_ST, SIG_LCNT} sig_e;
  typedef struct {
    int    cyc;
    sig_e  sig;
    int    val;
    string tag;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t sb_keep[$];
  int       cyc = 0;
  int       tests_run = 0;
  int       tests_failed = 0;
  int       pdn_low_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_push(input int c, input sig_e s, input int v, input string tag);
    sb_item_t it;
    it.cyc = c;
    it.sig = s;
    it.val = v;
    it.tag = tag;
    sb_q.push_back(it);
  endtask

  function automatic int sample_sig(input sig_e s);
    case (s)
      SIG_FAB:  return int'(fabric_reset_n);
      SIG_PDN:  return int'(pll_powerdown_n);
      SIG_LL:   return int'(lock_lost);
      SIG_FLT:  return int'(fault);
      SIG_ST:   return int'(state);
`ifdef PLL_LOCK_LOSS_CNT_EN
      SIG_LCNT: return int'(loss_cnt);
`endif
      default:  return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (resetn === 1'b1 && pll_powerdown_n === 1'b0) pdn_low_cnt++;
    sb_keep.delete();
    foreach (sb_q[i]) begin
      if (sb_q[i].cyc == cyc)
        check_val(sb_q[i].tag, sample_sig(sb_q[i].sig), sb_q[i].val);
      else if (sb_q[i].cyc < cyc)
        check_val({sb_q[i].tag, "_late"}, cyc, sb_q[i].cyc);
      else
        sb_keep.push_back(sb_q[i]);
    end
    sb_q = sb_keep;
  end

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_fab"},   int'(fabric_reset_n),  0);
    check_val({pfx, "_pdn"},   int'(pll_powerdown_n), 1);
    check_val({pfx, "_ll"},    int'(lock_lost),       0);
    check_val({pfx, "_fault"}, int'(fault),           0);
    check_val({pfx, "_state"}, int'(state),           0);
`ifdef PLL_LOCK_LOSS_CNT_EN
    check_val({pfx, "_lcnt"},  int'(loss_cnt),        0);
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    pll_lock  = 1'b0;
    ext_rst_n = 1'b1;
    go_to(3);
    check_reset_values("por");
    resetn = 1'b1;

    // clean bring-up: lock rises after edge 20, release on edge 47
    sb_push(5,  SIG_ST, 0, "boot_idle");
    sb_push(6,  SIG_ST, 1, "boot_wait");
    sb_push(23, SIG_ST, 2, "up_stable");
    sb_push(39, SIG_ST, 3, "up_hold");
    sb_push(46, SIG_FAB, 0, "up_fab_pre");
    sb_push(47, SIG_FAB, 1, "up_fab");
    sb_push(47, SIG_ST, 4, "up_run");
    sb_push(47, SIG_LL, 0, "up_ll");
    sb_push(47, SIG_PDN, 1, "up_pdn");
    go_to(20);
    pll_lock = 1'b1;

    // loss in RUN after edge 50
    sb_push(52, SIG_FAB, 1, "loss_fab_pre");
    sb_push(53, SIG_FAB, 0, "loss_fab");
    sb_push(53, SIG_LL, 1, "loss_ll");
    sb_push(53, SIG_ST, 1, "loss_wait");
    go_to(50);
    pll_lock = 1'b0;

    // relock with a 3-cycle glitch at stable count 10
    sb_push(70, SIG_ST, 2, "glitch_stable");
    sb_push(71, SIG_ST, 1, "glitch_wait");
    sb_push(74, SIG_ST, 2, "glitch_restable");
    sb_push(97, SIG_FAB, 0, "glitch_fab_pre");
    sb_push(98, SIG_FAB, 1, "glitch_fab");
    sb_push(98, SIG_LL, 1, "glitch_ll_sticky");
`ifdef PLL_LOCK_LOSS_CNT_EN
    sb_push(98, SIG_LCNT, 1, "lcnt_1");
`endif
    go_to(55);
    pll_lock = 1'b1;
    go_to(68);
    pll_lock = 1'b0;
    go_to(71);
    pll_lock = 1'b1;

    // lock drop landing on the HOLD terminal-count edge
    sb_push(103, SIG_ST, 1, "tc_wait");
`ifdef PLL_LOCK_LOSS_CNT_EN
    sb_push(103, SIG_LCNT, 2, "lcnt_2");
`endif
    sb_push(130, SIG_ST, 3, "tc_hold");
    sb_push(131, SIG_ST, 1, "tc_abort");
    sb_push(131, SIG_FAB, 0, "tc_fab");
    sb_push(159, SIG_FAB, 1, "tc_release");
    go_to(100);
    pll_lock = 1'b0;
    go_to(104);
    pll_lock = 1'b1;
    go_to(128);
    pll_lock = 1'b0;
    go_to(132);
    pll_lock = 1'b1;

    // ext reset and lock loss together: ext wins, no loss counted
    sb_push(167, SIG_FAB, 1, "ext_fab_pre");
    sb_push(167, SIG_LL, 1, "ext_ll_pre");
    sb_push(168, SIG_FAB, 0, "ext_fab");
    sb_push(168, SIG_ST, 0, "ext_idle");
    sb_push(168, SIG_LL, 0, "ext_ll_clr");
`ifdef PLL_LOCK_LOSS_CNT_EN
    sb_push(170, SIG_LCNT, 2, "lcnt_ext_hold");
`endif
    go_to(165);
    ext_rst_n = 1'b0;
    pll_lock  = 1'b0;

    // no lock: two PD pulses then FAULT
    sb_push(173, SIG_ST, 1, "nl_wait");
    sb_push(272, SIG_PDN, 1, "nl_pd1_pre");
    sb_push(273, SIG_PDN, 0, "nl_pd1");
    sb_push(273, SIG_ST, 5, "nl_pd1_state");
    sb_push(282, SIG_PDN, 0, "nl_pd1_end");
    sb_push(283, SIG_PDN, 1, "nl_pd1_done");
    sb_push(283, SIG_ST, 1, "nl_wait2");
    sb_push(382, SIG_PDN, 1, "nl_pd2_pre");
    sb_push(383, SIG_PDN, 0, "nl_pd2");
    sb_push(392, SIG_PDN, 0, "nl_pd2_end");
    sb_push(393, SIG_PDN, 1, "nl_pd2_done");
    sb_push(492, SIG_ST, 1, "nl_wait3");
    sb_push(493, SIG_ST, 6, "nl_fault_state");
    sb_push(493, SIG_FLT, 1, "nl_fault");
    sb_push(493, SIG_FAB, 0, "nl_fab");
    sb_push(493, SIG_PDN, 1, "nl_no_pd3");
    sb_push(600, SIG_ST, 6, "nl_fault_stays");
    go_to(170);
    ext_rst_n = 1'b1;
    go_to(600);
    check_val("pd_low_cycles_2", pdn_low_cnt, 20);

    // recovery from FAULT via ext, then normal release
    sb_push(603, SIG_FLT, 0, "rec_fault_clr");
    sb_push(603, SIG_ST, 0, "rec_idle");
    sb_push(608, SIG_ST, 1, "rec_wait");
    sb_push(636, SIG_FAB, 0, "rec_fab_pre");
    sb_push(637, SIG_FAB, 1, "rec_fab");
    sb_push(637, SIG_ST, 4, "rec_run");
    ext_rst_n = 1'b0;
    go_to(605);
    ext_rst_n = 1'b1;
    go_to(610);
    pll_lock = 1'b1;

    // retries were cleared: a fresh timeout enters PD, not FAULT
    sb_push(643, SIG_ST, 1, "rt_wait");
    sb_push(643, SIG_LL, 1, "rt_ll");
`ifdef PLL_LOCK_LOSS_CNT_EN
    sb_push(643, SIG_LCNT, 3, "lcnt_3");
`endif
    sb_push(743, SIG_ST, 5, "rt_pd");
    sb_push(753, SIG_ST, 1, "rt_wait2");
    sb_push(754, SIG_ST, 2, "rt_stable");
    sb_push(770, SIG_ST, 3, "rt_hold");
    sb_push(774, SIG_ST, 3, "rt_hold_mid");
    go_to(640);
    pll_lock = 1'b0;
    go_to(745);
    pll_lock = 1'b1;

    // async reset mid-HOLD, checked without any clock edge
    go_to(775);
    check_val("pd_low_cycles_3", pdn_low_cnt, 30);
    check_val("pre_rst_ll", int'(lock_lost), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values("async");
    go_to(780);
    resetn = 1'b1;
    sb_push(782, SIG_ST, 0, "rs_idle");
    sb_push(783, SIG_ST, 1, "rs_wait");
    sb_push(784, SIG_ST, 2, "rs_stable");
    sb_push(807, SIG_FAB, 0, "rs_fab_pre");
    sb_push(808, SIG_FAB, 1, "rs_fab");
    sb_push(808, SIG_LL, 0, "rs_ll");
`ifdef PLL_LOCK_LOSS_CNT_EN
    sb_push(808, SIG_LCNT, 0, "rs_lcnt");
`endif

    go_to(815);
    check_val("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
